// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The master issues req/addr and receives a one-cycle ack with rdata.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks req/ack to imem, holds IF/ID,
// and applies the decode-stage next-PC redirect with a one-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [1:0]  NPC_PC4    = 2'd0,
  parameter logic [1:0]  NPC_BRANCH = 2'd1,
  parameter logic [1:0]  NPC_JUMP   = 2'd2,
  parameter logic [1:0]  NPC_JR     = 2'd3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          npcOp,
  input  logic [31:0]         rsValD,
  input  logic                stallD,
  fetch_unit_if.master        imem,
  output logic [31:0]         instrD,
  output logic [31:0]         pcPlus4D,
  output logic                validD
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        drop_q, drop_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redir;
  logic        accept;
  logic        ack_f;
  logic [31:0] target;

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = addr_q;
  assign instrD         = instr_q;
  assign pcPlus4D       = pc4_q;
  assign validD         = valid_q;

  always_comb begin
    redir  = valid_q & ~stallD & (npcOp != NPC_PC4);
    accept = ~valid_q | ~stallD;
    ack_f  = (state_q == S_FETCH) & imem.imem_ack;

    case (npcOp)
      NPC_BRANCH: target = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      NPC_JUMP:   target = {pc4_q[31:28], instr_q[25:0], 2'b00};
      NPC_JR:     target = rsValD & 32'hFFFF_FFFC;
      default:    target = pc4_q;
    endcase

    state_d     = state_q;
    addr_d      = addr_q;
    drop_d      = drop_q;
    tgt_d       = tgt_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;

    // IF/ID load: redirect bubble beats skid buffer beats fresh word
    if (accept) begin
      if (redir) begin
        valid_d = 1'b0;
      end else if (state_q == S_HOLD) begin
        instr_d = buf_instr_q;
        pc4_d   = buf_pc4_q;
        valid_d = 1'b1;
      end else if (ack_f && !drop_q) begin
        instr_d = imem.imem_rdata;
        pc4_d   = addr_q + 32'd4;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (ack_f) begin
          if (drop_q || redir) begin
            drop_d = 1'b0;
            addr_d = redir ? target : tgt_q;
          end else if (accept) begin
            addr_d = addr_q + 32'd4;
          end else begin
            buf_instr_d = imem.imem_rdata;
            buf_pc4_d   = addr_q + 32'd4;
            addr_d      = addr_q + 32'd4;
            state_d     = S_HOLD;
          end
        end else if (redir) begin
          // request already in flight: remember where to go once it returns
          drop_d = 1'b1;
          tgt_d  = target;
        end
      end
      S_HOLD: begin
        if (redir) begin
          addr_d  = target;
          state_d = S_FETCH;
        end else if (accept) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= RESET_PC;
      drop_q      <= 1'b0;
      tgt_q       <= 32'd0;
      buf_instr_q <= 32'd0;
      buf_pc4_q   <= 32'd0;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      drop_q      <= drop_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall/skid, redirects,
// redirect with a request in flight, and reset in the middle of a request.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  npcOp;
  logic [31:0] rsValD;
  logic        stallD;
  logic [31:0] instrD;
  logic [31:0] pcPlus4D;
  logic        validD;
  logic        ack_auto;
  logic        ack_man;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit_if bus ();

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_300C: return 32'h1000_FFFF;
      32'h3000_001C: return 32'h0800_0C10;
      default:       return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  assign bus.imem_ack   = ack_auto ? bus.imem_req : ack_man;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .npcOp    (npcOp),
    .rsValD   (rsValD),
    .stallD   (stallD),
    .imem     (bus),
    .instrD   (instrD),
    .pcPlus4D (pcPlus4D),
    .validD   (validD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; npcOp = 2'd0; rsValD = 32'd0; stallD = 1'b0;
    ack_auto = 1'b1; ack_man = 1'b0;
    step; step;
    rst = 1'b1;
    step;
  endtask

  task automatic test_reset;
    rst = 1'b0; npcOp = 2'd0; rsValD = 32'd0; stallD = 1'b0;
    ack_auto = 1'b1; ack_man = 1'b0;
    step; step;
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h3000) begin n_err++; $display("FAIL rst_addr: got %h want 00003000", bus.imem_addr); end
    n_cmp++; if ({instrD, pcPlus4D, validD} !== 65'd0) begin n_err++; $display("FAIL rst_ifid: got %h %h %b want 0 0 0", instrD, pcPlus4D, validD); end
    rst = 1'b1;
    step;
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin n_err++; $display("FAIL first_req: got %b %h want 1 00003000", bus.imem_req, bus.imem_addr); end
    n_cmp++; if (validD !== 1'b0) begin n_err++; $display("FAIL first_valid: got %b want 0", validD); end
    step;
    n_cmp++; if (bus.imem_addr !== 32'h3004) begin n_err++; $display("FAIL seq_addr1: got %h want 00003004", bus.imem_addr); end
    n_cmp++; if (instrD !== 32'hA5A5_3000 || pcPlus4D !== 32'h3004 || validD !== 1'b1) begin n_err++; $display("FAIL seq_ifid1: got %h %h %b want a5a53000 00003004 1", instrD, pcPlus4D, validD); end
    step;
    n_cmp++; if (bus.imem_addr !== 32'h3008) begin n_err++; $display("FAIL seq_addr2: got %h want 00003008", bus.imem_addr); end
    n_cmp++; if (instrD !== 32'hA5A5_3004 || pcPlus4D !== 32'h3008) begin n_err++; $display("FAIL seq_ifid2: got %h %h want a5a53004 00003008", instrD, pcPlus4D); end
  endtask

  task automatic test_stall;
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      n_cmp++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h300C) begin n_err++; $display("FAIL stall_req%0d: got %b %h want 0 0000300c", i, bus.imem_req, bus.imem_addr); end
      n_cmp++; if (instrD !== 32'hA5A5_3004 || pcPlus4D !== 32'h3008 || validD !== 1'b1) begin n_err++; $display("FAIL stall_ifid%0d: got %h %h %b want a5a53004 00003008 1", i, instrD, pcPlus4D, validD); end
    end
    stallD = 1'b0;
    step;
    n_cmp++; if (instrD !== 32'hA5A5_3008 || pcPlus4D !== 32'h300C || validD !== 1'b1) begin n_err++; $display("FAIL skid_out: got %h %h %b want a5a53008 0000300c 1", instrD, pcPlus4D, validD); end
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300C) begin n_err++; $display("FAIL resume_req: got %b %h want 1 0000300c", bus.imem_req, bus.imem_addr); end
    step;
    n_cmp++; if (instrD !== 32'h1000_FFFF || pcPlus4D !== 32'h3010) begin n_err++; $display("FAIL resume_ifid: got %h %h want 1000ffff 00003010", instrD, pcPlus4D); end
  endtask

  task automatic test_branch;
    do_reset;
    repeat (4) step;
    n_cmp++; if (instrD !== 32'h1000_FFFF || pcPlus4D !== 32'h3010 || bus.imem_addr !== 32'h3010) begin n_err++; $display("FAIL br_setup: got %h %h %h want 1000ffff 00003010 00003010", instrD, pcPlus4D, bus.imem_addr); end
    npcOp = 2'd1;
    step;
    npcOp = 2'd0;
    n_cmp++; if (validD !== 1'b0 || bus.imem_addr !== 32'h300C) begin n_err++; $display("FAIL br_redir: got %b %h want 0 0000300c", validD, bus.imem_addr); end
    step;
    n_cmp++; if (instrD !== 32'h1000_FFFF || pcPlus4D !== 32'h3010 || validD !== 1'b1) begin n_err++; $display("FAIL br_target: got %h %h %b want 1000ffff 00003010 1", instrD, pcPlus4D, validD); end
  endtask

  task automatic test_jump_jr;
    do_reset;
    step;
    npcOp = 2'd3; rsValD = 32'h3000_001C;
    step;
    npcOp = 2'd0;
    n_cmp++; if (bus.imem_addr !== 32'h3000_001C || validD !== 1'b0) begin n_err++; $display("FAIL jr1_addr: got %h %b want 3000001c 0", bus.imem_addr, validD); end
    step;
    n_cmp++; if (instrD !== 32'h0800_0C10 || pcPlus4D !== 32'h3000_0020) begin n_err++; $display("FAIL j_setup: got %h %h want 08000c10 30000020", instrD, pcPlus4D); end
    npcOp = 2'd2;
    step;
    npcOp = 2'd0;
    n_cmp++; if (bus.imem_addr !== 32'h3000_3040 || validD !== 1'b0) begin n_err++; $display("FAIL j_addr: got %h %b want 30003040 0", bus.imem_addr, validD); end
    step;
    n_cmp++; if (pcPlus4D !== 32'h3000_3044 || validD !== 1'b1) begin n_err++; $display("FAIL j_ifid: got %h %b want 30003044 1", pcPlus4D, validD); end
    npcOp = 2'd3; rsValD = 32'h0000_3107;
    step;
    npcOp = 2'd0;
    n_cmp++; if (bus.imem_addr !== 32'h0000_3104) begin n_err++; $display("FAIL jr2_addr: got %h want 00003104", bus.imem_addr); end
    step;
    n_cmp++; if (instrD !== 32'hA5A5_3104 || pcPlus4D !== 32'h3108) begin n_err++; $display("FAIL jr2_ifid: got %h %h want a5a53104 00003108", instrD, pcPlus4D); end
  endtask

  task automatic test_redirect_outstanding;
    do_reset;
    step;
    ack_auto = 1'b0; ack_man = 1'b0;
    npcOp = 2'd3; rsValD = 32'h0000_3100;
    step;
    npcOp = 2'd0;
    n_cmp++; if (validD !== 1'b0 || bus.imem_addr !== 32'h3004 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL out_wait1: got %b %h %b want 0 00003004 1", validD, bus.imem_addr, bus.imem_req); end
    step;
    n_cmp++; if (bus.imem_addr !== 32'h3004 || bus.imem_req !== 1'b1) begin n_err++; $display("FAIL out_wait2: got %h %b want 00003004 1", bus.imem_addr, bus.imem_req); end
    ack_man = 1'b1;
    step;
    ack_man = 1'b0;
    n_cmp++; if (validD !== 1'b0 || bus.imem_addr !== 32'h3100) begin n_err++; $display("FAIL out_drop: got %b %h want 0 00003100", validD, bus.imem_addr); end
    ack_auto = 1'b1;
    step;
    n_cmp++; if (instrD !== 32'hA5A5_3100 || pcPlus4D !== 32'h3104 || validD !== 1'b1) begin n_err++; $display("FAIL out_target: got %h %h %b want a5a53100 00003104 1", instrD, pcPlus4D, validD); end
  endtask

  task automatic test_reset_mid;
    ack_auto = 1'b0; ack_man = 1'b0;
    step;
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %b want 1", bus.imem_req); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h3000) begin n_err++; $display("FAIL mid_rst_bus: got %b %h want 0 00003000", bus.imem_req, bus.imem_addr); end
    n_cmp++; if ({instrD, pcPlus4D, validD} !== 65'd0) begin n_err++; $display("FAIL mid_rst_ifid: got %h %h %b want 0 0 0", instrD, pcPlus4D, validD); end
    ack_man = 1'b1;
    #2;
    rst = 1'b1;
    step;
    ack_man = 1'b0;
    n_cmp++; if (validD !== 1'b0) begin n_err++; $display("FAIL mid_idle_ack: got %b want 0", validD); end
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin n_err++; $display("FAIL mid_restart: got %b %h want 1 00003000", bus.imem_req, bus.imem_addr); end
    ack_auto = 1'b1;
    step;
    n_cmp++; if (instrD !== 32'hA5A5_3000 || pcPlus4D !== 32'h3004 || validD !== 1'b1) begin n_err++; $display("FAIL mid_first: got %h %h %b want a5a53000 00003004 1", instrD, pcPlus4D, validD); end
  endtask

  initial begin
    test_reset;
    test_stall;
    test_branch;
    test_jump_jr;
    test_redirect_outstanding;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipeline. It owns the fetch PC and issues requests on a req/ack instruction-memory interface. It holds the IF/ID pipeline register, and applies the `npcOp` redirect produced by the ID-stage control unit. `npcOp` is already resolved against `isRsRtEq`, so taken and not-taken branches arrive as distinct codes. This block is the consumer of that next-PC command and the sole source of `instrD`/`pcPlus4D` for decode.

## Interface

Parameters:
- `RESET_PC`, 32'h0000_3000, first fetch address after reset.
- `NPC_PC4`, 2'd0, `npcOp` code: sequential.
- `NPC_BRANCH`, 2'd1, `npcOp` code: taken branch.
- `NPC_JUMP`, 2'd2, `npcOp` code: j/jal.
- `NPC_JR`, 2'd3, `npcOp` code: jr/jalr.

Ports:
- `clk`, in, 1, sole clock; all state updates on the rising edge.
- `rst`, in, 1, asynchronous, active-low reset.
- `npcOp`, in, 2, next-PC command for the instruction currently in `instrD`.
- `rsValD`, in, 32, forwarded rs value, used for `NPC_JR`.
- `stallD`, in, 1, hazard unit holds ID; IF/ID must not change.
- `imem_req`, out, 1, fetch request.
- `imem_addr`, out, 32, word address of the request; `[1:0]` always 0.
- `imem_ack`, in, 1, one-cycle pulse; `imem_rdata` is valid in that cycle.
- `imem_rdata`, in, 32, fetched instruction.
- `instrD`, out, 32, IF/ID instruction.
- `pcPlus4D`, out, 32, IF/ID PC+4.
- `validD`, out, 1, IF/ID holds a real instruction (0 = bubble).

## Operation

States:
- IDLE
  - Entered only by reset.
  - Moves to FETCH on the next edge.
  - `imem_req`=0.
- FETCH
  - `imem_req`=1 and `imem_addr`=`addr_q`.
  - `addr_q` and `imem_req` are held stable until the cycle `imem_ack`=1.
- HOLD
  - Entered when a fetched word returns but IF/ID cannot accept it.
  - The word and its PC+4 go into a one-entry skid buffer.
  - `imem_req`=0.

Redirect:
- `redir` = `validD` & !`stallD` & (`npcOp` != `NPC_PC4`).
- Target by `npcOp`:
  - `NPC_BRANCH`: `pcPlus4D` + ({{14{instrD[15]}}, instrD[15:0], 2'b00}).
  - `NPC_JUMP`: {`pcPlus4D`[31:28], `instrD`[25:0], 2'b00}.
  - `NPC_JR`: {`rsValD`[31:2], 2'b00}.
- All adds are 32-bit and wrap modulo 2^32. There is no delay slot: the sequential successor of the redirecting instruction is discarded.

IF/ID update:
- `accept` = !`validD` | !`stallD`.
- When `accept`, IF/ID loads in this priority order:
  1. If `redir`, a bubble (`validD`=0). `instrD`/`pcPlus4D` keep their old values.
  2. Otherwise, if in HOLD, the skid buffer.
  3. Otherwise, if `imem_ack` arrives with no pending drop, `imem_rdata` and `addr_q`+4.
  4. Otherwise, a bubble.
- When !`accept`, IF/ID holds.

FETCH transitions on `imem_ack`:
- `drop_q`=1 or `redir` this cycle:
  - Discard the word and clear `drop_q`.
  - `addr_q` ← the pending target (`tgt_q`, or this cycle's target).
  - Stay in FETCH.
- Else if `accept`:
  - Word goes to IF/ID.
  - `addr_q` ← `addr_q`+4.
  - Stay in FETCH.
- Else: word goes to the skid buffer, `addr_q` ← `addr_q`+4, go to HOLD.

FETCH with `redir` but no `imem_ack`:
- Set `drop_q`=1 and `tgt_q` ← target.
- The outstanding request stays unchanged.
- A later `redir` before the ack overwrites `tgt_q`.

HOLD transitions:
- `redir`: discard the buffer, `addr_q` ← target, go to FETCH.
- Else if `accept`: buffer goes to IF/ID, go to FETCH.

## Timing

- Reset (`rst`=0, asynchronous) gives:
  - state IDLE, `addr_q`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `instrD`=0, `pcPlus4D`=0, `validD`=0.
  - `drop_q`=0, `tgt_q`=0, buffer empty.
- First `imem_req`=1 is in the first cycle after the first edge following `rst` release.
- Fetch latency:
  - The ack cycle's word appears on `instrD` with `validD`=1 one cycle after `imem_ack`.
  - With zero-wait memory (ack the same cycle as req), sustained throughput is one instruction per cycle.
- Redirect penalty:
  - A redirect decided in cycle N produces a bubble in IF/ID at N+1.
  - With zero-wait memory, `imem_addr`=target in cycle N+1 and the target word is on `instrD` at N+2.
- Reset asserted mid-request:
  - Abandons the request and returns to IDLE immediately.
  - A late `imem_ack` while in IDLE is ignored.
- `imem_ack` outside FETCH is ignored.

## Test plan

- **Reset and first fetch:** reset, release, zero-wait ack → `imem_addr` sequence 3000, 3004, 3008. `instrD` follows one cycle behind with `pcPlus4D` 3004, 3008.
- **Stall:**
  - Stimulus: `stallD`=1 for 3 cycles during zero-wait streaming.
  - Required: IF/ID is frozen and exactly one word is parked in HOLD with `imem_req`=0.
  - On release, that word enters IF/ID and fetch resumes at the next address. No word is lost or duplicated.
- **Taken branch:** `instrD`=32'h1000_FFFF (offset −1), `pcPlus4D`=3010, `npcOp`=`NPC_BRANCH` → next `validD`=0, then `imem_addr`=300C.
- **Jump and jr:**
  - `NPC_JUMP` with `instrD`[25:0]=26'h0000C10 and `pcPlus4D`=3000_0020 → target 3000_3040.
  - `NPC_JR` with `rsValD`=0000_3104 → target 0000_3104.
- **Redirect during outstanding request:**
  - Stimulus: ack delayed 3 cycles, redirect to 3100 in the first wait cycle.
  - Required: `imem_addr` stays constant until the ack and the returned word is dropped (`validD`=0). The next request is at 3100.
- **Reset mid-request:** assert `rst` while `imem_req`=1 → outputs immediately take their reset values. Fetch restarts at 3000 after release.
